multicycle_ctrl: RTL
====================

# multicycle_ctrl

Finite-state controller that sequences a multi-cycle RV32I datapath, a subset of the single-cycle core. One shared memory port serves both instruction fetch and data access, and the PC, IR, OldPC and ALUOut registers live in the datapath. The controller decodes the opcode class, emits per-state mux selects and write strobes, handles a req/ready memory handshake with arbitrary wait states, and traps on unsupported opcodes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  7  IR[6:0]; valid from DECODE onward
- funct3  in  3  IR[14:12]; used only for the branch decision
- zeroFlag  in  1  ALU zero flag from the datapath
- memReady  in  1  memory completed the current access this cycle
- memReq  out  1  memory access request
- memWe  out  1  write enable, qualified by memReq
- iOrD  out  1  memory address source: 0 = PC, 1 = ALUOut
- irWrite  out  1  load IR and OldPC from the fetched word and PC
- pcWrite  out  1  load PC
- pcSrc  out  1  PC source: 0 = ALU result (PC+4), 1 = ALUOut (branch target)
- ALUSrcA  out  1  ALU A input: 0 = PC/OldPC, 1 = rs1
- ALUSrcB  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = immediate
- ALUOp  out  2  ALU op: 00 = add, 01 = subtract/compare, 10 = decode funct3/funct7
- regWrite  out  1  register file write
- memToReg  out  1  writeback source: 1 = memory data, 0 = ALUOut
- state  out  3  current state, for debug
- illegal  out  1  sticky trap flag
- cycleCount  out  32  performance counter (see Configuration)
- instRet  out  32  performance counter (see Configuration)

## Operation
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Opcode classes:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - any other value is illegal.
- The class is latched into an internal register on leaving DECODE.
- FETCH:
  - Drives memReq=1, iOrD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - When memReady=1: irWrite=1, pcWrite=1, pcSrc=0, go to DECODE.
  - Otherwise holds in FETCH with both strobes low.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=10, ALUOp=00; the datapath latches OldPC+imm into ALUOut.
  - Legal opcode goes to EXEC; illegal opcode goes to TRAP.
- EXEC:
  - R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, go to WB.
  - I: ALUSrcA=1, ALUSrcB=10, ALUOp=10, go to WB.
  - LOAD/STORE: ALUSrcA=1, ALUSrcB=10, ALUOp=00, go to MEM.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, pcSrc=1, go to FETCH.
    - pcWrite = zeroFlag when funct3=000 (beq).
    - pcWrite = !zeroFlag when funct3=001 (bne).
    - pcWrite = 0 for any other funct3 (not taken, no trap).
- MEM:
  - Drives memReq=1, iOrD=1, memWe = (class==STORE).
  - Holds in MEM until memReady=1.
  - On memReady: LOAD goes to WB; STORE goes to FETCH.
- WB: regWrite=1, memToReg = (class==LOAD), go to FETCH.
- TRAP: every strobe and memReq is 0; illegal=1; the block stays in TRAP until rst.
- Outputs not listed for a state are 0.
- memReady is ignored outside FETCH and MEM.

## Timing
- Outputs are Moore from state. The only combinational terms are: irWrite/pcWrite gated by memReady in FETCH, and the branch pcWrite from zeroFlag/funct3.
- Latency with zero-wait memory (memReady high in the same cycle as memReq):
  - R / I / STORE: 4 cycles
  - LOAD: 5 cycles
  - BRANCH: 3 cycles
  - Each memReady-low cycle in FETCH or MEM adds exactly 1 cycle.
- Reset:
  - While rst=1, every output is 0, including memReq, state=0, illegal=0 and the counters.
  - On the first clock edge with rst=0, the block enters FETCH.
- Reset mid-operation: rst in any state forces all outputs to 0 in that same cycle. A pending store is abandoned; the memory treats a memReq drop as an abort. No partial register write occurs.
- memReady and rst high together: rst wins; no strobe fires.

## Configuration
- MULTICYCLE_PERF_EN defined:
  - cycleCount increments every cycle with rst=0.
  - instRet increments on each retiring transition: WB→FETCH, STORE MEM→FETCH, BRANCH EXEC→FETCH.
  - Both counters wrap from 0xFFFFFFFF to 0. Both are cleared by rst; TRAP does not count as a retire.
- MULTICYCLE_PERF_EN undefined: both ports remain and are tied to 0; no counter logic is built.

## Test plan
- Reset, then opcode=0110011 with memReady=1 constantly → state sequence 0,1,2,4,0; ALUOp=10 in EXEC; regWrite=1 only in WB; memToReg=0.
- LOAD opcode=0000011 with memReady low for 2 MEM cycles → MEM held 3 cycles with memReq=1, iOrD=1, memWe=0; WB has memToReg=1; 7 cycles total.
- BRANCH funct3=000: zeroFlag=1 → pcWrite=1, pcSrc=1 in EXEC; zeroFlag=0 → pcWrite=0. funct3=001 gives the inverse. funct3=100 → pcWrite=0.
- opcode=1111111 → TRAP on the cycle after DECODE; illegal=1 and all strobes 0 for 10 cycles; rst clears illegal; next is FETCH.
- STORE in MEM with memReady=0, rst asserted → memReq=0 and memWe=0 in the same cycle; after rst release, state=FETCH and regWrite never pulses.
- With MULTICYCLE_PERF_EN: 3 back-to-back R-type instructions at zero wait → after 12 cycles, instRet=3 and cycleCount=12. Without the macro, both read 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencer for a multi-cycle RV32I datapath with a
// shared instruction/data memory port (req/ready handshake).
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined;
// otherwise cycleCount and instRet are tied to zero.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zeroFlag,
    input  logic        memReady,
    output logic        memReq,
    output logic        memWe,
    output logic        iOrD,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        pcSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        regWrite,
    output logic        memToReg,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] cycleCount,
    output logic [31:0] instRet
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R       = 3'd0,
        C_I       = 3'd1,
        C_LOAD    = 3'd2,
        C_STORE   = 3'd3,
        C_BRANCH  = 3'd4,
        C_ILLEGAL = 3'd5
    } class_t;

    state_t r_state;
    state_t w_next;
    class_t r_class;
    class_t w_class;

    // Opcode class decode from the live IR opcode field
    always_comb begin
        w_class = C_ILLEGAL;
        case (opcode)
            7'b0110011: w_class = C_R;
            7'b0010011: w_class = C_I;
            7'b0000011: w_class = C_LOAD;
            7'b0100011: w_class = C_STORE;
            7'b1100011: w_class = C_BRANCH;
            default:    w_class = C_ILLEGAL;
        endcase
    end

    // State register and instruction class latch (class captured on leaving DECODE)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_class <= C_R;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class <= w_class;
            end
        end
    end

    // Next-state and Moore outputs; reset forces every output low in the same cycle
    always_comb begin
        w_next   = r_state;
        memReq   = 1'b0;
        memWe    = 1'b0;
        iOrD     = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        regWrite = 1'b0;
        memToReg = 1'b0;
        illegal  = 1'b0;
        state    = r_state;

        case (r_state)
            S_FETCH: begin
                memReq  = 1'b1;
                ALUSrcB = 2'b01;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b10;
                w_next  = (w_class == C_ILLEGAL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (r_class)
                    C_R: begin
                        ALUOp  = 2'b10;
                        w_next = S_WB;
                    end
                    C_I: begin
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b10;
                        w_next  = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        ALUSrcB = 2'b10;
                        w_next  = S_MEM;
                    end
                    C_BRANCH: begin
                        ALUOp  = 2'b01;
                        pcSrc  = 1'b1;
                        w_next = S_FETCH;
                        case (funct3)
                            3'b000:  pcWrite = zeroFlag;
                            3'b001:  pcWrite = ~zeroFlag;
                            default: pcWrite = 1'b0;
                        endcase
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                memReq = 1'b1;
                iOrD   = 1'b1;
                memWe  = (r_class == C_STORE);
                if (memReady) begin
                    w_next = (r_class == C_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                memToReg = (r_class == C_LOAD);
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                w_next  = S_TRAP;
            end
            default: w_next = S_FETCH;
        endcase

        if (rst) begin
            memReq   = 1'b0;
            memWe    = 1'b0;
            iOrD     = 1'b0;
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            pcSrc    = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
            regWrite = 1'b0;
            memToReg = 1'b0;
            illegal  = 1'b0;
            state    = '0;
        end
    end

`ifdef MULTICYCLE_PERF_EN
    logic        w_retire;
    logic [31:0] r_cycleCount;
    logic [31:0] r_instRet;

    // Retiring transitions: WB->FETCH, store MEM->FETCH, branch EXEC->FETCH
    always_comb begin
        w_retire = (r_state == S_WB)
                 | ((r_state == S_MEM) && (r_class == C_STORE) && memReady)
                 | ((r_state == S_EXEC) && (r_class == C_BRANCH));
    end

    // Free-running cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycleCount <= '0;
            r_instRet    <= '0;
        end else begin
            r_cycleCount <= r_cycleCount + 32'd1;
            if (w_retire) begin
                r_instRet <= r_instRet + 32'd1;
            end
        end
    end

    assign cycleCount = rst ? '0 : r_cycleCount;
    assign instRet    = rst ? '0 : r_instRet;
`else
    assign cycleCount = '0;
    assign instRet    = '0;
`endif

endmodule
